// File: rtl/ahb_ssram_ctrl.sv
//------------------------------------------------------------------------------
// ahb_ssram_ctrl : AHB-Lite slave front-end for a 4-lane synchronous SRAM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ahb_ssram_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    RD_DATA = 3'd2,
    RD_WAIT = 3'd3,
    ERR1    = 3'd4,
    ERR2    = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic                  wr_q;
  logic                  err_q;
  logic [3:0]            mask_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  accept;
  logic                  ready_state;
  logic                  err_c;
  logic [3:0]            mask_c;

  // Upper address bits alias and HTRANS[0] does not affect the decode
  logic unused_bits;
  assign unused_bits = &{1'b0, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign accept      = HSEL & HTRANS[1] & HREADY;
  assign ready_state = (state == IDLE) || (state == WR_DATA) ||
                       (state == RD_DATA) || (state == ERR2);

  always_comb begin
    mask_c = 4'h0;
    case (HSIZE)
      3'd0:    mask_c = 4'b0001 << HADDR[1:0];
      3'd1:    mask_c = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    mask_c = 4'b1111;
      default: mask_c = 4'h0;
    endcase
  end

  assign err_c = (HSIZE > 3'd2) ||
                 ((HSIZE == 3'd1) && HADDR[0]) ||
                 ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  assign HRDATA  = ram_dout;
  assign ram_din = HWDATA;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      mask_q <= 4'h0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (ready_state && accept) begin
        wr_q   <= HWRITE;
        err_q  <= err_c;
        mask_q <= mask_c;
        addr_q <= HADDR[ADDR_WIDTH+1:2];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 4'h0;
    ram_addr  = addr_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;

    case (state)
      WR_DATA: begin
        ram_en = 1'b1;
        ram_we = mask_q & {4{wr_q & ~err_q}};
      end
      RD_WAIT: begin
        ram_en    = 1'b1;
        HREADYOUT = 1'b0;
        state_nxt = RD_DATA;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: begin
        HRESP = 1'b1;
      end
      default: ;
    endcase

    // A new address phase can only land while the slave is ready
    if (ready_state) begin
      state_nxt = IDLE;
      if (accept) begin
        if (err_c) begin
          state_nxt = ERR1;
        end else if (HWRITE) begin
          state_nxt = WR_DATA;
        end else if (state == WR_DATA) begin
          state_nxt = RD_WAIT;
        end else begin
          state_nxt = RD_DATA;
          ram_en    = 1'b1;
          ram_we    = 4'h0;
          ram_addr  = HADDR[ADDR_WIDTH+1:2];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_ssram_ctrl.sv
//------------------------------------------------------------------------------
// tb_ahb_ssram_ctrl : directed self-checking bench with a 4-lane RAM model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ahb_ssram_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [31:0]   hwdata;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = 32'h0;

  logic [31:0]   mem [0:(1<<AW)-1];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  ahb_ssram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK      (clk),
    .HRESETn   (rst_n),
    .HSEL      (hsel),
    .HADDR     (haddr),
    .HTRANS    (htrans),
    .HWRITE    (hwrite),
    .HSIZE     (hsize),
    .HWDATA    (hwdata),
    .HREADY    (hreadyout),
    .HREADYOUT (hreadyout),
    .HRESP     (hresp),
    .HRDATA    (hrdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Write-first RAM, four byte lanes, preloaded with a recognisable pattern
  initial begin
    logic [31:0] w;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'hC0DE0000 | i;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        w = mem[ram_addr];
        for (int l = 0; l < 4; l++)
          if (ram_we[l]) w[8*l +: 8] = ram_din[8*l +: 8];
        mem[ram_addr] <= w;
        ram_dout      <= w;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic ap(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [1:0] t);
    hsel   = 1'b1;
    haddr  = a;
    hwrite = w;
    hsize  = s;
    htrans = t;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = 3'd2;
  endtask

  initial begin
    rst_n  = 1'b0;
    hwdata = 32'h0;
    bus_idle();
    step();
    step();
    settle();
    check("rst_hready", {31'h0, hreadyout}, 32'h1);
    check("rst_hresp",  {31'h0, hresp},     32'h0);
    check("rst_ram_en", {31'h0, ram_en},    32'h0);
    check("rst_ram_we", {28'h0, ram_we},    32'h0);
    step();
    rst_n = 1'b1;

    // Reset asserted in the data phase of a write drops the write
    ap(1'b1, 32'h20, 3'd2, 2'b10);
    settle();
    check("wr_ap_no_en", {31'h0, ram_en}, 32'h0);
    step();
    bus_idle();
    hwdata = 32'h11111111;
    settle();
    check("wr_dp_en", {31'h0, ram_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_en",     {31'h0, ram_en},    32'h0);
    check("midrst_we",     {28'h0, ram_we},    32'h0);
    check("midrst_hready", {31'h0, hreadyout}, 32'h1);
    check("midrst_hresp",  {31'h0, hresp},     32'h0);
    step();
    rst_n = 1'b1;
    ap(1'b0, 32'h20, 3'd2, 2'b10);
    settle();
    check("postrst_rd_en",   {31'h0, ram_en}, 32'h1);
    check("postrst_rd_addr", {22'h0, ram_addr}, 32'h8);
    step();
    bus_idle();
    settle();
    check("postrst_hready", {31'h0, hreadyout}, 32'h1);
    check("postrst_rdata",  hrdata, 32'hC0DE0008);

    // Word write then back-to-back read of the same address
    step();
    ap(1'b1, 32'h10, 3'd2, 2'b10);
    step();
    hwdata = 32'hDEADBEEF;
    ap(1'b0, 32'h10, 3'd2, 2'b10);
    settle();
    check("ww_we",     {28'h0, ram_we},   32'hF);
    check("ww_addr",   {22'h0, ram_addr}, 32'h4);
    check("ww_hready", {31'h0, hreadyout}, 32'h1);
    step();
    bus_idle();
    settle();
    check("rw_wait_hready", {31'h0, hreadyout}, 32'h0);
    check("rw_wait_en",     {31'h0, ram_en},    32'h1);
    check("rw_wait_we",     {28'h0, ram_we},    32'h0);
    step();
    settle();
    check("rw_hready", {31'h0, hreadyout}, 32'h1);
    check("rw_rdata",  hrdata, 32'hDEADBEEF);

    // Sub-word lanes
    step();
    ap(1'b1, 32'h13, 3'd0, 2'b10);
    step();
    hwdata = 32'hAA000000;
    ap(1'b1, 32'h10, 3'd1, 2'b10);
    settle();
    check("byte_we", {28'h0, ram_we}, 32'h8);
    step();
    hwdata = 32'h00005555;
    ap(1'b0, 32'h10, 3'd2, 2'b10);
    settle();
    check("half_we", {28'h0, ram_we}, 32'h3);
    step();
    bus_idle();
    settle();
    check("sub_wait", {31'h0, hreadyout}, 32'h0);
    step();
    settle();
    check("sub_rdata", hrdata, 32'hAAAD5555);

    // Pipelined reads
    step();
    ap(1'b0, 32'h0, 3'd2, 2'b10);
    settle();
    check("p0_en",   {31'h0, ram_en},   32'h1);
    check("p0_addr", {22'h0, ram_addr}, 32'h0);
    step();
    ap(1'b0, 32'h4, 3'd2, 2'b11);
    settle();
    check("p0_hready", {31'h0, hreadyout}, 32'h1);
    check("p0_rdata",  hrdata, 32'hC0DE0000);
    check("p1_en",     {31'h0, ram_en}, 32'h1);
    step();
    ap(1'b0, 32'h8, 3'd2, 2'b11);
    settle();
    check("p1_hready", {31'h0, hreadyout}, 32'h1);
    check("p1_rdata",  hrdata, 32'hC0DE0001);
    check("p2_addr",   {22'h0, ram_addr}, 32'h2);
    step();
    bus_idle();
    settle();
    check("p2_hready", {31'h0, hreadyout}, 32'h1);
    check("p2_rdata",  hrdata, 32'hC0DE0002);
    check("p_idle_en", {31'h0, ram_en}, 32'h0);

    // Misaligned word read
    step();
    ap(1'b0, 32'h2, 3'd2, 2'b10);
    settle();
    check("e1_ap_en", {31'h0, ram_en}, 32'h0);
    step();
    bus_idle();
    settle();
    check("e1_c1", {30'h0, hreadyout, hresp}, 32'h1);
    check("e1_c1_en", {31'h0, ram_en}, 32'h0);
    step();
    settle();
    check("e1_c2", {30'h0, hreadyout, hresp}, 32'h3);
    step();
    settle();
    check("e1_done", {30'h0, hreadyout, hresp}, 32'h2);

    // Misaligned half write, then a valid read accepted in ERR2
    step();
    ap(1'b1, 32'h1, 3'd1, 2'b10);
    step();
    hwdata = 32'hFFFFFFFF;
    bus_idle();
    settle();
    check("e2_c1", {30'h0, hreadyout, hresp}, 32'h1);
    check("e2_c1_en", {31'h0, ram_en}, 32'h0);
    step();
    ap(1'b0, 32'h0, 3'd2, 2'b10);
    settle();
    check("e2_c2", {30'h0, hreadyout, hresp}, 32'h3);
    check("e2_c2_rd_en", {31'h0, ram_en}, 32'h1);
    step();
    bus_idle();
    settle();
    check("e2_rd_resp",  {30'h0, hreadyout, hresp}, 32'h2);
    check("e2_rd_rdata", hrdata, 32'hC0DE0000);

    // Unsupported size
    step();
    ap(1'b1, 32'h4, 3'd3, 2'b10);
    step();
    bus_idle();
    settle();
    check("e3_c1", {30'h0, hreadyout, hresp}, 32'h1);
    check("e3_c1_en", {31'h0, ram_en}, 32'h0);
    step();
    settle();
    check("e3_c2", {30'h0, hreadyout, hresp}, 32'h3);
    step();
    ap(1'b0, 32'h4, 3'd2, 2'b10);
    step();
    bus_idle();
    settle();
    check("e3_mem", hrdata, 32'hC0DE0001);

    // Aliasing
    step();
    ap(1'b1, 32'h1000, 3'd2, 2'b10);
    step();
    hwdata = 32'h12345678;
    bus_idle();
    settle();
    check("alias_addr", {22'h0, ram_addr}, 32'h0);
    check("alias_we",   {28'h0, ram_we},   32'hF);
    step();
    ap(1'b0, 32'h0, 3'd2, 2'b10);
    step();
    bus_idle();
    settle();
    check("alias_rdata", hrdata, 32'h12345678);

    // Non-accepted address phases
    step();
    ap(1'b0, 32'h0, 3'd2, 2'b00);
    settle();
    check("idle_en", {31'h0, ram_en}, 32'h0);
    step();
    ap(1'b0, 32'h0, 3'd2, 2'b01);
    settle();
    check("busy_en", {31'h0, ram_en}, 32'h0);
    step();
    ap(1'b1, 32'h0, 3'd2, 2'b10);
    hsel = 1'b0;
    settle();
    check("nosel_en", {31'h0, ram_en}, 32'h0);
    step();
    settle();
    check("nosel_dp_en", {31'h0, ram_en}, 32'h0);
    bus_idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_ssram_ctrl.md
# ahb_ssram_ctrl

AHB-Lite slave that converts bus transfers into single-port synchronous SRAM accesses. It sits directly upstream of four byte-lane instances of the team's write-first synchronous RAM (8-bit word, `ADDR_WIDTH` address bits), one instance per lane of `ram_we`. Reads and writes are zero-wait-state except a read that immediately follows a write, which takes one wait state. Unsupported or misaligned transfers get a two-cycle ERROR response.

## Interface
- `ADDR_WIDTH`, 10: RAM word-address width; memory size is 4·2^ADDR_WIDTH bytes; upper HADDR bits are ignored (aliasing).
- `HCLK`  in  1: single clock; all logic is posedge.
- `HRESETn`  in  1: asynchronous, active-low reset.
- `HSEL`  in  1: slave select.
- `HADDR`  in  32: byte address.
- `HTRANS`  in  2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HWRITE`  in  1: 1 = write.
- `HSIZE`  in  3: 0 = byte, 1 = half, 2 = word, >2 = unsupported.
- `HWDATA`  in  32: write data, valid in the data phase.
- `HREADY`  in  1: bus-level ready; an address phase is accepted when HSEL & HTRANS[1] & HREADY.
- `HREADYOUT`  out  1: slave ready.
- `HRESP`  out  1: 0 = OKAY, 1 = ERROR.
- `HRDATA`  out  32: read data, driven as `ram_dout`.
- `ram_en`  out  1: RAM enable.
- `ram_we`  out  4: per-byte-lane write enable; lane i covers bits [8i+7:8i].
- `ram_addr`  out  ADDR_WIDTH: word address.
- `ram_din`  out  32: write data.
- `ram_dout`  in  32: RAM read data, one cycle after `ram_en`.

## Operation
- **Lane mask (little-endian):**
  - byte: 1<<HADDR[1:0]
  - half: 2'b11<<{HADDR[1],1'b0}
  - word: 4'hF
- **Error conditions:** an accepted transfer is in error if it is misaligned or unsupported.
  - Misaligned: half with HADDR[0]=1, or word with HADDR[1:0]≠0.
  - Unsupported: HSIZE>2.
- **Address phase (accepted transfer):** the block registers write flag, lane mask, word address (HADDR[ADDR_WIDTH+1:2]) and the error flag.
- **States:**
  - **IDLE/READY** (default): HREADYOUT=1, HRESP=0.
  - **WR_DATA**: data phase of a valid write. `ram_en`=1, `ram_we`=registered mask, `ram_addr`=registered address, `ram_din`=HWDATA.
  - **RD_DATA**: data phase of a valid read whose RAM access was issued in the address phase. HRDATA=`ram_dout`, HREADYOUT=1.
  - **RD_WAIT**: data phase of a read that collided with a write. The block issues the RAM read from the registered address with HREADYOUT=0, then moves to RD_DATA.
  - **ERR1**: HREADYOUT=0, HRESP=1.
  - **ERR2**: HREADYOUT=1, HRESP=1.
- **Read issue:** a valid accepted read with no write in its data phase drives `ram_en`=1, `ram_we`=0 and `ram_addr`=HADDR word bits combinationally in the same cycle (address phase). Next state is RD_DATA.
- **Read-after-write collision:** the RAM port belongs to the write. The read address is registered and the next state is RD_WAIT.
- **Write after write or read:** the write is registered and the next state is WR_DATA.
- **Erroneous transfer:** no RAM access; goes to ERR1 then ERR2. No new address is accepted during ERR1, because HREADY is low. An address phase accepted during ERR2 is processed normally.
- **Other address phases:** IDLE, BUSY, HSEL=0 or HREADY=0 issue no RAM access. From a ready state with no accepted transfer, the next state is IDLE.
- **Write data:** HWDATA is passed whole on `ram_din`; unused lanes are masked by `ram_we`.

## Timing
- **Reset values:** HREADYOUT=1, HRESP=0, `ram_en`=0, `ram_we`=0, state IDLE, all registered address/control fields 0. HRDATA follows `ram_dout`.
- **Reset mid-operation:** returns to IDLE immediately, asynchronously. Any pending write or RAM access in flight is dropped.
- **Read latency:** address phase at cycle N, HRDATA valid at cycle N+1. After a write: HRDATA valid at N+2, with HREADYOUT=0 at N+1.
- **Write:** committed at the posedge that ends the data phase. A read of the same address issued immediately after returns the new data.
- **ERROR:** exactly 2 cycles, with HRESP=1 in both.
- **Outputs:** `ram_en`, `ram_we`, `ram_addr` and `ram_din` are combinational from state, registers and bus inputs. No combinational path from `ram_dout` other than to HRDATA.

## Test plan
- **Reset:** assert HRESETn=0 mid-write → HREADYOUT=1, HRESP=0, `ram_en`=0, `ram_we`=0. After release, the first read completes with zero wait states.
- **Word write/read:** write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → `ram_we`=F and `ram_addr`=4 in the write data phase. Read takes one RD_WAIT cycle, then HRDATA=0xDEADBEEF.
- **Sub-word lanes:**
  - Write byte 0xAA to 0x13 → `ram_we`=8.
  - Write half 0x5555 to 0x10 → `ram_we`=3.
  - Then read word 0x10 → HRDATA=0xAA??5555, with byte 2 unchanged.
- **Pipelined reads:** NONSEQ/SEQ reads at 0x0, 0x4, 0x8 → three consecutive cycles with HREADYOUT=1 and the correct data each cycle; `ram_en` high during each address phase.
- **Errors:**
  - Word read at 0x2, half write at 0x1, HSIZE=3 → each gives 2 cycles HRESP=1 (HREADYOUT 0 then 1). No `ram_en` pulse; memory is unchanged.
  - A valid transfer accepted in ERR2 completes normally.
- **Aliasing/idle:** write to 0x1000 with ADDR_WIDTH=10 → `ram_addr`=0. IDLE and BUSY transfers and HSEL=0 never assert `ram_en`.
